// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolve unit.
//   - PC_WIDTH_DEF : default PC / target width
//   - bp_state_e   : resolve FSM state encoding (RUN / FLUSH)
//   - queue entry layout helpers. An entry is packed as {pc, taken, target}:
//       target in [pw-1:0], taken at bit pw, pc in [2*pw:pw+1].
package bp_pkg;

  localparam int PC_WIDTH_DEF = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bp_state_e;

  function automatic int ent_width(input int pw);
    return 2 * pw + 1;
  endfunction

  function automatic int ent_taken_bit(input int pw);
    return pw;
  endfunction

  function automatic int ent_pc_lsb(input int pw);
    return pw + 1;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue.
// Ports:
//   clk, reset      : clock, async active-high reset
//   push, din       : write din at the tail (dropped when full unless popping)
//   pop             : drop the head entry (ignored when empty)
//   flush           : empty the queue at the next edge; overrides push/pop
//   full, empty     : occupancy status
//   head            : oldest entry (undefined when empty)
module pred_fifo #(
  parameter int W         = 65,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0]         mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 wr, rd;

  assign full  = (count == (PTR_WIDTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop && !empty;
  // A pop in the same cycle frees a slot, so push at full is legal then.
  assign wr    = push && (!full || rd);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({wr, rd})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-time predictions, compares them with
// execute-stage outcomes, raises a one-cycle mispredict/redirect and keeps
// resolve statistics.
// Ports:
//   clk, reset                         : clock, async active-high reset
//   pred_push/pc/taken/target          : prediction from fetch
//   ex_valid/pc/taken/target           : resolution of the oldest branch
//   stall_fetch                        : queue full or flushing
//   actual_valid/taken/pc/target       : registered predictor/BTB update
//   mispredict, recover_pc             : one-cycle redirect pulse
//   order_err                          : sticky head-PC mismatch flag
//   branch_count, mispredict_count     : saturating statistics
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_push,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  input  logic                 pred_taken,
  input  logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_taken,
  input  logic [PC_WIDTH-1:0]  ex_target,
  output logic                 stall_fetch,
  output logic                 actual_valid,
  output logic                 actual_taken,
  output logic [PC_WIDTH-1:0]  actual_pc,
  output logic [PC_WIDTH-1:0]  actual_target,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  recover_pc,
  output logic                 order_err,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int EW  = ent_width(PC_WIDTH);
  localparam int TKN = ent_taken_bit(PC_WIDTH);
  localparam int PCL = ent_pc_lsb(PC_WIDTH);

  bp_state_e           state, state_nxt;
  logic                q_full, q_empty, q_push;
  logic [EW-1:0]       q_din, q_head;
  logic [PC_WIDTH-1:0] h_pc, h_target, redirect;
  logic                h_taken;
  logic                mis_det, pc_err;

  assign q_din    = {pred_pc, pred_taken, pred_target};
  assign h_pc     = q_head[PCL +: PC_WIDTH];
  assign h_taken  = q_head[TKN];
  assign h_target = q_head[PC_WIDTH-1:0];

  // Fetch pushes are wrong-path while flushing; a same-cycle mispredict
  // also discards the push through the queue's flush input.
  assign q_push = pred_push && (state == ST_RUN);

  pred_fifo #(
    .W         (EW),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (ex_valid),
    .flush (mis_det),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  // Compare the outcome with the head prediction; an empty queue behaves
  // as an implicit not-taken prediction.
  always_comb begin
    mis_det = 1'b0;
    pc_err  = 1'b0;
    if (ex_valid) begin
      if (q_empty) begin
        mis_det = ex_taken;
      end else begin
        mis_det = (ex_taken != h_taken) || (ex_taken && (ex_target != h_target));
        pc_err  = (ex_pc != h_pc);
      end
    end
  end

  assign redirect = ex_taken ? ex_target : (ex_pc + PC_WIDTH'(4));

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // FSM: next state; FLUSH always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (mis_det) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_fetch = q_full || (state == ST_FLUSH);
  end

  // Registered update / redirect, zero whenever nothing resolved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      actual_valid  <= 1'b0;
      actual_taken  <= 1'b0;
      actual_pc     <= '0;
      actual_target <= '0;
      mispredict    <= 1'b0;
      recover_pc    <= '0;
    end else begin
      actual_valid  <= ex_valid;
      actual_taken  <= ex_valid && ex_taken;
      actual_pc     <= ex_valid ? ex_pc : '0;
      actual_target <= ex_valid ? ex_target : '0;
      mispredict    <= mis_det;
      recover_pc    <= mis_det ? redirect : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_err        <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pc_err) order_err <= 1'b1;
      if (ex_valid && (branch_count != '1))
        branch_count <= branch_count + CNT_WIDTH'(1);
      if (mis_det && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk, reset;
  logic          pred_push, pred_taken, ex_valid, ex_taken;
  logic [31:0]   pred_pc, pred_target, ex_pc, ex_target;
  logic          stall_fetch, actual_valid, actual_taken, mispredict, order_err;
  logic [31:0]   actual_pc, actual_target, recover_pc;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.PC_WIDTH(32), .DEPTH(4), .PTR_WIDTH(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .pred_push(pred_push), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .stall_fetch(stall_fetch), .actual_valid(actual_valid), .actual_taken(actual_taken),
    .actual_pc(actual_pc), .actual_target(actual_target), .mispredict(mispredict),
    .recover_pc(recover_pc), .order_err(order_err),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic push; logic [31:0] ppc; logic pt; logic [31:0] ptgt;
    logic exv;  logic [31:0] expc; logic ext; logic [31:0] extgt;
    logic mis;  logic [31:0] rec; logic stall;
  } vec_t;

  typedef struct {
    logic av; logic at; logic [31:0] apc; logic [31:0] atgt; logic mis; logic [31:0] rec;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_bc  = 0;
  int   exp_mc  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive_idle();
    pred_push = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
  endtask

  // One cycle: drive at negedge, record expectation, compare at next negedge.
  task automatic tick(input logic push, input logic [31:0] ppc, input logic pt, input logic [31:0] ptgt,
                      input logic exv, input logic [31:0] expc, input logic ext, input logic [31:0] extgt,
                      input logic mis, input logic [31:0] rec);
    exp_t e;
    pred_push = push; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
    ex_valid = exv; ex_pc = expc; ex_taken = ext; ex_target = extgt;
    e.av = exv; e.at = exv & ext; e.apc = exv ? expc : 32'h0; e.atgt = exv ? extgt : 32'h0;
    e.mis = mis; e.rec = mis ? rec : 32'h0;
    sb.push_back(e);
    if (exv && exp_bc != SAT) exp_bc++;
    if (mis && exp_mc != SAT) exp_mc++;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("actual_valid", actual_valid, e.av);
      chk("actual_taken", actual_taken, e.at);
      chk("actual_pc", actual_pc, e.apc);
      chk("actual_target", actual_target, e.atgt);
      chk("mispredict", mispredict, e.mis);
      chk("recover_pc", recover_pc, e.rec);
      chk("branch_count", branch_count, exp_bc);
      chk("mispredict_count", mispredict_count, exp_mc);
    end
  endtask

  task automatic push_only(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    tick(1, pc, t, tgt, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ex_only(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic mis, input logic [31:0] rec);
    tick(0, 0, 0, 0, 1, pc, t, tgt, mis, rec);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall_fetch, 0);
    chk({tag, "_actual_valid"}, actual_valid, 0);
    chk({tag, "_actual_taken"}, actual_taken, 0);
    chk({tag, "_actual_pc"}, actual_pc, 0);
    chk({tag, "_actual_target"}, actual_target, 0);
    chk({tag, "_mispredict"}, mispredict, 0);
    chk({tag, "_recover_pc"}, recover_pc, 0);
    chk({tag, "_order_err"}, order_err, 0);
    chk({tag, "_branch_count"}, branch_count, 0);
    chk({tag, "_mispredict_count"}, mispredict_count, 0);
  endtask

  vec_t vecs[12];

  initial begin
    // push, ppc, pt, ptgt, exv, expc, ext, extgt, mis, rec, stall-after
    vecs[0]  = '{1, 32'h100, 1, 32'h200, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0};
    vecs[1]  = '{0, 32'h0, 0, 32'h0, 1, 32'h100, 1, 32'h200, 0, 32'h0, 0};
    vecs[2]  = '{1, 32'h104, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0};
    vecs[3]  = '{0, 32'h0, 0, 32'h0, 1, 32'h104, 1, 32'h300, 1, 32'h300, 1};
    vecs[4]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0};
    vecs[5]  = '{0, 32'h0, 0, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0};
    vecs[6]  = '{0, 32'h0, 0, 32'h0, 1, 32'h500, 1, 32'h600, 1, 32'h600, 1};
    vecs[7]  = '{1, 32'h700, 1, 32'h800, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0};
    vecs[8]  = '{0, 32'h0, 0, 32'h0, 1, 32'h700, 0, 32'h0, 0, 32'h0, 0};
    vecs[9]  = '{1, 32'hFFFFFFFC, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0};
    vecs[10] = '{0, 32'h0, 0, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 32'h0, 1};
    vecs[11] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0};

    drive_idle();
    reset = 1'b1;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: basic resolve, mispredict, empty-queue, flush-ignores-push, wrap
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].push, vecs[i].ppc, vecs[i].pt, vecs[i].ptgt,
           vecs[i].exv, vecs[i].expc, vecs[i].ext, vecs[i].extgt,
           vecs[i].mis, vecs[i].rec);
      chk($sformatf("vec%0d_stall", i), stall_fetch, vecs[i].stall);
    end

    // Fill, drop on full, push+pop at full, drain in order
    for (int i = 1; i <= 4; i++) push_only(32'(i * 16), 1, 32'(i * 16 + 32'h1000));
    chk("full_stall", stall_fetch, 1);
    push_only(32'h50, 1, 32'h1050);
    chk("full_drop_stall", stall_fetch, 1);
    tick(1, 32'h60, 1, 32'h1060, 1, 32'h10, 1, 32'h1010, 0, 0);
    chk("full_pushpop_stall", stall_fetch, 1);
    ex_only(32'h20, 1, 32'h1020, 0, 0);
    chk("drain1_stall", stall_fetch, 0);
    ex_only(32'h30, 1, 32'h1030, 0, 0);
    ex_only(32'h40, 1, 32'h1040, 0, 0);
    ex_only(32'h60, 1, 32'h1060, 0, 0);
    chk("drain_order_err", order_err, 0);

    // Mispredict discards a same-cycle push
    push_only(32'h900, 1, 32'h904);
    tick(1, 32'hA00, 1, 32'hB00, 1, 32'h900, 0, 32'h0, 1, 32'h904);
    chk("flush_stall", stall_fetch, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_done_stall", stall_fetch, 0);
    ex_only(32'hA00, 0, 32'h0, 0, 0);

    // Head PC mismatch: sticky order_err, entry still compared/popped
    push_only(32'hC00, 1, 32'hD00);
    ex_only(32'hC04, 1, 32'hD00, 0, 0);
    chk("order_err_set", order_err, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("order_err_sticky", order_err, 1);

    // Reset in the FLUSH cycle following a mispredict with 3 entries queued
    push_only(32'h10, 1, 32'h1010);
    push_only(32'h20, 1, 32'h1020);
    push_only(32'h30, 1, 32'h1030);
    ex_only(32'h10, 0, 32'h0, 1, 32'h14);
    chk("pre_reset_stall", stall_fetch, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("midflush");
    // Traffic while held in reset must leave no trace
    pred_push = 1; pred_pc = 32'h80; pred_taken = 1; pred_target = 32'h90;
    ex_valid = 1; ex_pc = 32'h80; ex_taken = 1; ex_target = 32'h99;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("inreset");
    drive_idle();
    sb.delete();
    exp_bc = 0;
    exp_mc = 0;
    reset = 1'b0;
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_stall", stall_fetch, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_only(32'h10, 0, 32'h0, 0, 0);
    chk("post_reset_order_err", order_err, 0);

    // Counter saturation: taken resolves on an empty queue all mispredict
    for (int i = 0; i < SAT + 3; i++) ex_only(32'(i * 4), 1, 32'h2000, 1, 32'h2000);
    chk("bc_saturated", branch_count, SAT);
    chk("mc_saturated", mispredict_count, SAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001: Parameter PC_WIDTH, default 32, PC and target width.
REQ-002: Parameter DEPTH, default 4, in-flight prediction queue entries.
REQ-003: Parameter PTR_WIDTH, default 2, log2(DEPTH).
REQ-004: Parameter CNT_WIDTH, default 16, statistics counter width.
REQ-005: clk  input  1  single clock; all state changes on its rising edge.
REQ-006: reset  input  1  asynchronous, active-high reset.
REQ-007: pred_push  input  1  fetch issued a branch carrying a prediction.
REQ-008: pred_pc  input  PC_WIDTH  PC of the pushed branch.
REQ-009: pred_taken  input  1  predicted direction.
REQ-010: pred_target  input  PC_WIDTH  predicted target; ignored when pred_taken=0.
REQ-011: ex_valid  input  1  execute stage resolved the oldest branch this cycle.
REQ-012: ex_pc, ex_taken, ex_target  input  PC_WIDTH/1/PC_WIDTH  resolved PC, direction and target.
REQ-013: stall_fetch  output  1  queue full, or state FLUSH.
REQ-014: actual_valid, actual_taken, actual_pc, actual_target  output  1/1/PC_WIDTH/PC_WIDTH  registered update to predictor and BTB.
REQ-015: mispredict  output  1  one-cycle pulse; flush younger instructions.
REQ-016: recover_pc  output  PC_WIDTH  redirect PC, valid while mispredict=1.
REQ-017: order_err  output  1  sticky flag: ex_pc did not match the head entry's PC.
REQ-018: branch_count, mispredict_count  output  CNT_WIDTH  resolved-branch and mispredict counters.

Function
REQ-019: The queue SHALL be FIFO; push writes {pc,taken,target} at the tail, and ex_valid pops the head.
REQ-020: A push while full SHALL be dropped and the queue left unchanged.
REQ-021: Push and pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-022: The mispredict condition (head present) SHALL be ex_taken != head.taken, or both taken with ex_target != head.target.
REQ-023: ex_valid with an empty queue SHALL compare against an implicit not-taken prediction.
REQ-024: actual_* and mispredict SHALL be registered, asserted exactly one cycle after the ex_valid cycle, and zero otherwise.
REQ-025: recover_pc SHALL be ex_target if ex_taken, else ex_pc+4, computed modulo 2^PC_WIDTH with wrap-around.
REQ-026: The FSM SHALL have states RUN and FLUSH; RUN->FLUSH on a detected mispredict; FLUSH->RUN after exactly one cycle.
REQ-027: On a detected mispredict, the queue SHALL be emptied at the next edge, and a same-cycle push SHALL be discarded as wrong-path.
REQ-028: In FLUSH, pred_push SHALL be ignored; ex_valid SHALL still be resolved against the (empty) queue.
REQ-029: A head PC mismatch SHALL set order_err until reset; the entry is still popped and compared.
REQ-030: branch_count SHALL increment per ex_valid; mispredict_count SHALL increment per mispredict; both SHALL saturate at all-ones.

Reset
REQ-031: Reset SHALL force state RUN, empty queue, pointers 0, all outputs 0, order_err 0 and both counters 0, immediately and regardless of clk.
REQ-032: Reset asserted mid-flush or mid-transfer SHALL abandon the operation; no actual_valid or mispredict pulse follows deassertion.

Structure
REQ-033: PC_WIDTH default, the FSM state encoding (RUN/FLUSH) and the queue entry field layout SHALL live in a shared package bp_pkg.
REQ-034: The queue SHALL be one sub-module, pred_fifo, with push/pop/flush, full/empty and head outputs; comparison, FSM and counters stay in branch_resolve_unit.

Verification
REQ-035: Push (0x100,T,0x200); ex_valid (0x100,T,0x200) -> next cycle: actual_valid=1, mispredict=0, branch_count=1.
REQ-036: Push (0x104,NT); ex (0x104,T,0x300) -> mispredict=1, recover_pc=0x300, 1 cycle of stall_fetch, queue empty, mispredict_count=1.
REQ-037: Push 4 entries -> stall_fetch=1; a 5th push is dropped; simultaneous push+pop at full keeps occupancy 4 in order.
REQ-038: ex_valid on empty queue with ex_taken=0, ex_pc=0xFFFFFFFC -> mispredict=0; with ex_taken=1 -> mispredict=1; NT recover_pc wrap check gives 0x0.
REQ-039: Mispredict with a same-cycle push -> pushed entry absent; ex_pc mismatch -> order_err stays 1 until reset.
REQ-040: Assert reset mid-FLUSH with 3 entries queued -> all outputs 0 immediately; no pulses after release.
